// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller: each digit slot starts with a
// blanking interval (all anodes off), then lights the selected anode.
module display_scan_controller #(
  parameter int DIVIDE       = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [3:0] i_digit_en,
  output logic [1:0] o_sel,
  output logic [3:0] o_an,
  output logic       o_digit_tick
);

  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SHOW_LAST  = CNT_WIDTH'(DIVIDE - BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]           r_sel, w_sel_nxt;
  logic [3:0]           r_an, w_an_nxt;
  logic                 r_tick, w_tick_nxt;
  logic [3:0]           w_lit_an;

  // Anode pattern for the current select; a disabled digit stays dark.
  assign w_lit_an = i_digit_en[r_sel] ? ~(4'b0001 << r_sel) : 4'b1111;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_sel   <= 2'd0;
      r_an    <= 4'b1111;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_an    <= w_an_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
    w_sel_nxt   = r_sel;
    w_an_nxt    = 4'b1111;
    w_tick_nxt  = 1'b0;
    // Disable wins over a terminal count, so SEL never advances while dark.
    if (!i_enable) begin
      w_state_nxt = ST_BLANK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_cnt_nxt   = '0;
            w_an_nxt    = w_lit_an;
          end
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_sel_nxt   = r_sel + 2'd1;
            w_tick_nxt  = 1'b1;
          end else begin
            w_an_nxt = w_lit_an;
          end
        end
        default: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_sel        = r_sel;
  assign o_an         = r_an;
  assign o_digit_tick = r_tick;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIVIDE=8, BLANK_CYCLES=2.
module tb_display_scan_controller;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] digit_en;
  logic [1:0] sel;
  logic [3:0] an;
  logic       tick;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  display_scan_controller #(.DIVIDE(8), .BLANK_CYCLES(2), .CNT_WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_digit_en  (digit_en),
    .o_sel       (sel),
    .o_an        (an),
    .o_digit_tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] lit(input logic [1:0] s, input logic [3:0] en);
    return en[s] ? ~(4'b0001 << s) : 4'b1111;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; digit_en = 4'b1111;
    repeat (2) @(negedge clk);
    n_chk++;
    if (sel !== 2'd0 || an !== 4'b1111 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: sel=%0d an=%b tick=%b, want sel=0 an=1111 tick=0", sel, an, tick);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  // Cycles 0..9 after reset release.
  task automatic test_first_slot();
    for (int k = 0; k <= 9; k++) begin
      logic [1:0] e_sel;
      logic [3:0] e_an;
      logic       e_tick;
      if (k > 0) step();
      e_sel  = (k >= 8) ? 2'd1 : 2'd0;
      e_an   = (k >= 2 && k < 8) ? 4'b1110 : 4'b1111;
      e_tick = (k == 8);
      n_chk++;
      if (sel !== e_sel || an !== e_an || tick !== e_tick) begin
        n_fail++;
        $display("FAIL first_slot c%0d: sel=%0d an=%b tick=%b, want sel=%0d an=%b tick=%b",
                 k, sel, an, tick, e_sel, e_an, e_tick);
      end
    end
  endtask

  // Runs from the current cycle up to last_cyc, checking against slot arithmetic.
  task automatic run_slots(input string name, input int last_cyc);
    int         n_tick = 0;
    int         n_exp  = 0;
    logic [1:0] prev_sel;
    while (cyc < last_cyc) begin
      logic [1:0] e_sel;
      logic [3:0] e_an;
      logic       e_tick;
      prev_sel = sel;
      step();
      e_sel  = 2'((cyc / 8) % 4);
      e_an   = ((cyc % 8) < 2) ? 4'b1111 : lit(e_sel, digit_en);
      e_tick = ((cyc % 8) == 0);
      if (e_tick) n_exp++;
      if (tick === 1'b1) n_tick++;
      n_chk++;
      if (sel !== e_sel || an !== e_an || tick !== e_tick) begin
        n_fail++;
        $display("FAIL %s c%0d: sel=%0d an=%b tick=%b, want sel=%0d an=%b tick=%b",
                 name, cyc, sel, an, tick, e_sel, e_an, e_tick);
      end
      if (sel !== prev_sel) begin
        n_chk++;
        if (an !== 4'b1111) begin
          n_fail++;
          $display("FAIL %s_sel_change_dark c%0d: an=%b, want 1111", name, cyc, an);
        end
      end
      n_chk++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL %s_one_hot c%0d: an=%b, want at most one low bit", name, cyc, an);
      end
    end
    n_chk++;
    if (n_tick != n_exp) begin
      n_fail++;
      $display("FAIL %s_tick_count: got %0d, want %0d", name, n_tick, n_exp);
    end
  endtask

  task automatic test_full_frame();
    run_slots("frame", 40);
  endtask

  task automatic test_digit_en();
    digit_en = 4'b1010;
    run_slots("digit_en", 72);
    digit_en = 4'b1111;
  endtask

  task automatic test_enable();
    logic [3:0] e_an;
    while (cyc < 84) step();
    n_chk++;
    if (sel !== 2'd2 || an !== 4'b1011) begin
      n_fail++;
      $display("FAIL enable_pre: sel=%0d an=%b, want sel=2 an=1011", sel, an);
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (sel !== 2'd2 || an !== 4'b1111 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_low d%0d: sel=%0d an=%b tick=%b, want sel=2 an=1111 tick=0",
                 k, sel, an, tick);
      end
    end
    enable = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      e_an = (j >= 2 && j < 8) ? 4'b1011 : 4'b1111;
      n_chk++;
      if (sel !== (j == 8 ? 2'd3 : 2'd2) || an !== e_an || tick !== (j == 8)) begin
        n_fail++;
        $display("FAIL enable_resume j%0d: sel=%0d an=%b tick=%b, want sel=%0d an=%b tick=%b",
                 j, sel, an, tick, (j == 8 ? 3 : 2), e_an, (j == 8));
      end
    end
  endtask

  // Disable lands on the terminal SHOW count: SEL must not advance.
  task automatic test_enable_terminal();
    repeat (7) step();
    n_chk++;
    if (sel !== 2'd3 || an !== 4'b0111) begin
      n_fail++;
      $display("FAIL term_pre: sel=%0d an=%b, want sel=3 an=0111", sel, an);
    end
    enable = 1'b0;
    step();
    n_chk++;
    if (sel !== 2'd3 || an !== 4'b1111 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL term_disable: sel=%0d an=%b tick=%b, want sel=3 an=1111 tick=0", sel, an, tick);
    end
    enable = 1'b1;
    repeat (6) step();
    n_chk++;
    if (sel !== 2'd3 || an !== 4'b0111) begin
      n_fail++;
      $display("FAIL term_resume: sel=%0d an=%b, want sel=3 an=0111", sel, an);
    end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (sel !== 2'd0 || an !== 4'b1111 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: sel=%0d an=%b tick=%b, want sel=0 an=1111 tick=0", sel, an, tick);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    test_first_slot();
  endtask

  initial begin
    test_reset();
    test_first_slot();
    test_full_frame();
    test_digit_en();
    test_enable();
    test_enable_terminal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
